// File: rtl/lfsr_rand_bank.sv
// Purpose : multi-channel Galois-LFSR random source with seed load, warm-up discard, valid/ready output.
// Latency : first word valid WARMUP_CYCLES+2 enabled edges after a seed load or reset release.
// Backpressure: a held word (rand_ready_i=0) freezes rand_out_o and all channel states.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   enable_i       1: LFSRs may step this cycle (also gates the warm-up count)
//   seed_load_i    load derived seeds from seed_i into every channel, restart warm-up
//   seed_i         base seed; channel k gets rotl(seed_i, 8*k)
//   rand_ready_i   consumer accepts rand_out_o
//   rand_valid_o   rand_out_o holds an unconsumed word
//   rand_out_o     channel k sample in bits [k*OUT_WIDTH +: OUT_WIDTH], two's complement
//   busy_o         1 while discarding warm-up steps
//   lockup_fix_o   one-cycle pulse after a zero channel state was repaired
module lfsr_rand_bank #(
  parameter int unsigned           LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = 32'h80200003,
  parameter int unsigned           NUM_CH        = 4,
  parameter int unsigned           OUT_WIDTH     = 4,
  parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED  = 32'hAAAF696C,
  parameter int unsigned           WARMUP_CYCLES = 16,
  parameter bit                    SYMMETRIC     = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        seed_load_i,
  input  logic [LFSR_WIDTH-1:0]       seed_i,
  input  logic                        rand_ready_i,
  output logic                        rand_valid_o,
  output logic [NUM_CH*OUT_WIDTH-1:0] rand_out_o,
  output logic                        busy_o,
  output logic                        lockup_fix_o
);

  localparam int unsigned CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES);
  // Most-negative sample code 100..0; symmetric mode folds it onto zero.
  localparam logic [OUT_WIDTH-1:0] MOST_NEG = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  function automatic logic [LFSR_WIDTH-1:0] rotl(input logic [LFSR_WIDTH-1:0] v,
                                                 input int unsigned sh);
    logic [LFSR_WIDTH-1:0] r;
    r = v;
    if (sh != 0) r = (v << sh) | (v >> (LFSR_WIDTH - sh));
    return r;
  endfunction

  state_e                             fsm_q, fsm_d;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic                               filled_q, filled_d;
  logic [NUM_CH*OUT_WIDTH-1:0]        rand_out_q, rand_out_d;
  logic                               lockup_q, lockup_d;
  logic                               do_step;
  logic [NUM_CH-1:0]                  zero_ch;
  logic [NUM_CH-1:0][OUT_WIDTH-1:0]   samp;

  // Per-channel state. Samples come from the post-step value so a loaded
  // word always reflects the state the channel moves into on that edge.
  for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
    localparam int unsigned SH = (8 * k) % LFSR_WIDTH;
    localparam logic [LFSR_WIDTH-1:0] DSEED = rotl(DEFAULT_SEED, SH);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [LFSR_WIDTH-1:0] seed_k, load_val, step_val;
    logic [OUT_WIDTH-1:0]  raw;

    always_comb begin
      seed_k   = rotl(seed_i, SH);
      // Rotation preserves zero-ness, so only an all-zero base seed lands here.
      load_val = (seed_k == '0) ? DSEED : seed_k;
      // A zero state would stick forever; repair it instead of stepping.
      if (lfsr_q == '0) begin
        step_val = DSEED;
      end else if (lfsr_q[0]) begin
        step_val = (lfsr_q >> 1) ^ TAPS;
      end else begin
        step_val = lfsr_q >> 1;
      end
      lfsr_d = lfsr_q;
      if (seed_load_i) begin
        lfsr_d = load_val;
      end else if (do_step) begin
        lfsr_d = step_val;
      end
      raw = step_val[OUT_WIDTH-1:0];
    end

    assign zero_ch[k] = (lfsr_q == '0);
    assign samp[k]    = (SYMMETRIC && (raw == MOST_NEG)) ? '0 : raw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr_q <= DSEED;
      end else begin
        lfsr_q <= lfsr_d;
      end
    end
  end

  // Control: seed_load overrides everything and drops any pending word.
  always_comb begin
    fsm_d      = fsm_q;
    count_d    = count_q;
    filled_d   = filled_q;
    rand_out_d = rand_out_q;
    do_step    = 1'b0;
    if (seed_load_i) begin
      fsm_d    = ST_WARMUP;
      count_d  = CNT_INIT;
      filled_d = 1'b0;
    end else begin
      unique case (fsm_q)
        ST_WARMUP: begin
          if (enable_i) begin
            if (count_q != '0) begin
              do_step = 1'b1;
              count_d = count_q - CNT_W'(1);
            end else begin
              fsm_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!filled_q) begin
            if (enable_i) begin
              do_step    = 1'b1;
              filled_d   = 1'b1;
              rand_out_d = samp;
            end
          end else if (rand_ready_i) begin
            // Accepted word: refill back-to-back if allowed to step, else go empty
            // and leave the last value visible.
            if (enable_i) begin
              do_step    = 1'b1;
              rand_out_d = samp;
            end else begin
              filled_d = 1'b0;
            end
          end
        end
        default: fsm_d = ST_WARMUP;
      endcase
    end
  end

  assign lockup_d = do_step & (|zero_ch);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q      <= ST_WARMUP;
      count_q    <= CNT_INIT;
      filled_q   <= 1'b0;
      rand_out_q <= '0;
      lockup_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      count_q    <= count_d;
      filled_q   <= filled_d;
      rand_out_q <= rand_out_d;
      lockup_q   <= lockup_d;
    end
  end

  assign rand_valid_o = (fsm_q == ST_RUN) && filled_q;
  assign rand_out_o   = rand_out_q;
  assign busy_o       = (fsm_q == ST_WARMUP);
  assign lockup_fix_o = lockup_q;

endmodule

// File: tb/tb_lfsr_rand_bank.sv
// Purpose : directed self-checking bench for lfsr_rand_bank (default, zero-warm-up, non-symmetric builds).
// Latency : checks warm-up length, first-word latency and back-to-back refill.
// Backpressure: checks held words stay stable and enable=0 acceptance drops valid without stepping.
module tb_lfsr_rand_bank;

  localparam logic [31:0] DEF  = 32'hAAAF696C;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst_n, en, sl, rdy;
  logic [31:0] seed;

  logic        v0, b0, l0, v1, b1, l1, v2, b2, l2;
  logic [15:0] o0, o1, o2;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m [4];
  logic [15:0] exp_first;

  always #5 clk = ~clk;

  lfsr_rand_bank u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .seed_load_i(sl), .seed_i(seed),
    .rand_ready_i(rdy), .rand_valid_o(v0), .rand_out_o(o0), .busy_o(b0), .lockup_fix_o(l0));

  lfsr_rand_bank #(.WARMUP_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .seed_load_i(sl), .seed_i(seed),
    .rand_ready_i(rdy), .rand_valid_o(v1), .rand_out_o(o1), .busy_o(b1), .lockup_fix_o(l1));

  lfsr_rand_bank #(.WARMUP_CYCLES(0), .SYMMETRIC(1'b0)) u_w0s0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .seed_load_i(sl), .seed_i(seed),
    .rand_ready_i(rdy), .rand_valid_o(v2), .rand_out_o(o2), .busy_o(b2), .lockup_fix_o(l2));

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int sh);
    return (sh == 0) ? v : ((v << sh) | (v >> (32 - sh)));
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [3:0] symm(input logic [3:0] r);
    return (r == 4'h8) ? 4'h0 : r;
  endfunction

  function automatic logic [15:0] mword();
    return {symm(m[3][3:0]), symm(m[2][3:0]), symm(m[1][3:0]), symm(m[0][3:0])};
  endfunction

  task automatic model_seed_default();
    for (int k = 0; k < 4; k++) m[k] = rotl32(DEF, 8 * k);
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) m[k] = lstep(m[k]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sl = 1'b0; rdy = 1'b0; seed = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_out",   32'(o0), 32'd0);
    chk("rst_busy",  32'(b0), 32'd1);
    chk("rst_lock",  32'(l0), 32'd0);
    chk("rst_busy_w0s0", 32'(b2), 32'd1);
    chk("rst_lock_w0s0", 32'(l2), 32'd0);

    // Reset release with enable: 16 warm-up steps, RUN on 17th edge, valid on 18th
    rst_n = 1'b1; en = 1'b1;
    model_seed_default();
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i != 17) model_step();
      chk("t1_busy",  32'(b0), 32'(i <= 16));
      chk("t1_valid", 32'(v0), 32'(i >= 18));
    end
    exp_first = mword();
    chk("t1_first_word", 32'(o0), 32'(exp_first));

    // Held word under backpressure
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_valid", 32'(v0), 32'd1);
      chk("t5_hold_out",   32'(o0), 32'(exp_first));
    end
    // Accept with enable low: valid drops, value and states untouched
    en = 1'b0; rdy = 1'b1;
    tick();
    chk("t5_drop_valid", 32'(v0), 32'd0);
    chk("t5_drop_out",   32'(o0), 32'(exp_first));
    chk("t5_drop_busy",  32'(b0), 32'd0);
    en = 1'b1; rdy = 1'b0;
    tick();
    model_step();
    chk("t5_refill_valid", 32'(v0), 32'd1);
    chk("t5_refill_out",   32'(o0), 32'(mword()));

    // Back-to-back accepts, one new word per cycle
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      model_step();
      chk("b2b_valid", 32'(v0), 32'd1);
      chk("b2b_out",   32'(o0), 32'(mword()));
    end
    rdy = 1'b0;

    // seed_load in RUN with a pending word: word dropped, warm-up restarts
    seed = 32'h0; sl = 1'b1;
    tick();
    sl = 1'b0;
    chk("t6_run_load_valid", 32'(v0), 32'd0);
    chk("t6_run_load_busy",  32'(b0), 32'd1);
    repeat (5) tick();
    // seed_load again mid warm-up: count restarts from full
    sl = 1'b1;
    tick();
    sl = 1'b0;
    chk("t6_wu_load_busy",  32'(b0), 32'd1);
    chk("t6_wu_load_valid", 32'(v0), 32'd0);
    model_seed_default();
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i != 17) model_step();
      chk("t4_busy",  32'(b0), 32'(i <= 16));
      chk("t4_valid", 32'(v0), 32'(i >= 18));
    end
    // Zero seed must replay the reset sequence
    chk("t4_zero_seed_word", 32'(o0), 32'(exp_first));

    // Forced zero state on channel 0: repaired to DEFAULT_SEED on the next step
    force u_dut.gen_ch[0].lfsr_q = 32'h0;
    #1;
    release u_dut.gen_ch[0].lfsr_q;
    rdy = 1'b1;
    tick();
    model_step();
    m[0] = DEF;
    chk("lock_pulse",    32'(l0), 32'd1);
    chk("lock_ch0",      32'(o0[3:0]), 32'h0000000C);
    chk("lock_word",     32'(o0), 32'(mword()));
    tick();
    model_step();
    chk("lock_pulse_end", 32'(l0), 32'd0);
    chk("lock_ch0_next",  32'(o0[3:0]), 32'h00000006);
    chk("lock_word_next", 32'(o0), 32'(mword()));
    rdy = 1'b0;

    // Zero warm-up, seed 1
    seed = 32'h1; sl = 1'b1;
    tick();
    sl = 1'b0;
    chk("t2_load_valid", 32'(v1), 32'd0);
    tick();
    chk("t2_run_valid", 32'(v1), 32'd0);
    chk("t2_run_busy",  32'(b1), 32'd0);
    tick();
    chk("t2_valid",      32'(v1), 32'd1);
    chk("t2_word",       32'(o1), 32'h0003);
    chk("t2_word_nosym", 32'(o2), 32'h0003);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("t2_next_word",       32'(o1), 32'h0002);
    chk("t2_next_valid",      32'(v1), 32'd1);
    chk("t2_next_word_nosym", 32'(o2), 32'h0002);
    tick();
    chk("t2_held_word", 32'(o1), 32'h0002);
    chk("t2_lock_none", 32'(l1), 32'd0);

    // Symmetric folding of the most-negative code, seed 0x10
    seed = 32'h10; sl = 1'b1;
    tick();
    sl = 1'b0;
    tick();
    tick();
    chk("t3_sym_word",    32'(o1), 32'h0000);
    chk("t3_nosym_word",  32'(o2), 32'h0008);
    chk("t3_sym_valid",   32'(v1), 32'd1);
    chk("t3_nosym_valid", 32'(v2), 32'd1);

    // Asynchronous reset mid-RUN: outputs clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(v1), 32'd0);
    chk("t6_arst_out",   32'(o1), 32'd0);
    chk("t6_arst_busy",  32'(b1), 32'd1);
    chk("t6_arst_out2",  32'(o2), 32'd0);
    chk("t6_arst_valid_dut", 32'(v0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
